// File: rtl/if_id_buffer_pkg.sv
// Shared definitions for the IF/ID instruction buffer: default widths,
// the bubble word and the polarity constants used by its control logic.
package if_id_buffer_pkg;

  localparam int DefAddrW = 32;
  localparam int DefInstW = 32;

  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic        RstEnable = 1'b1;
  localparam logic        True_v    = 1'b1;

endpackage

// File: rtl/if_id_buffer_ring_ptr.sv
// Modulo-DEPTH ring pointer with synchronous clear and increment.
// DEPTH is a power of two, so the natural binary rollover is the wrap.
module ring_ptr
  import if_id_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clear,
  input  logic                       i_inc,
  output logic [$clog2(DEPTH)-1:0]   o_ptr
);

  localparam int PtrW = $clog2(DEPTH);

  logic [PtrW-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst == RstEnable || i_clear == True_v) begin
      r_ptr <= '0;
    end else if (i_inc == True_v) begin
      r_ptr <= r_ptr + PtrW'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/if_id_buffer.sv
// DEPTH-entry pc/instruction FIFO between fetch and decode with valid/ready
// handshakes on both sides and a single-cycle flush for redirects.
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int ADDR_W = DefAddrW,
  parameter int INST_W = DefInstW,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         if_valid,
  input  logic [ADDR_W-1:0]            if_pc,
  input  logic [INST_W-1:0]            if_inst,
  output logic                         if_ready,
  output logic                         id_valid,
  output logic [ADDR_W-1:0]            id_pc,
  output logic [INST_W-1:0]            id_inst,
  input  logic                         id_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] r_pc   [DEPTH];
  logic [INST_W-1:0] r_inst [DEPTH];
  logic [CntW-1:0]   r_cnt;

  logic [PtrW-1:0]   w_wp;
  logic [PtrW-1:0]   w_rp;
  logic              w_full;
  logic              w_empty;
  logic              w_enq;
  logic              w_deq;
  logic              w_kill;

  // Full/empty come from the explicit counter so DEPTH entries is unambiguous
  // and if_ready never depends combinationally on id_ready.
  assign w_full  = (r_cnt == CntW'(DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_kill  = (rst == RstEnable) || (flush == True_v);
  assign w_enq   = if_valid && !w_full && !w_kill;
  assign w_deq   = id_ready && !w_empty && !w_kill;

  ring_ptr #(.DEPTH(DEPTH)) u_wp (
    .clk     (clk),
    .rst     (rst),
    .i_clear (flush),
    .i_inc   (w_enq),
    .o_ptr   (w_wp)
  );

  ring_ptr #(.DEPTH(DEPTH)) u_rp (
    .clk     (clk),
    .rst     (rst),
    .i_clear (flush),
    .i_inc   (w_deq),
    .o_ptr   (w_rp)
  );

  always_ff @(posedge clk) begin
    if (w_kill) begin
      r_cnt <= '0;
    end else if (w_enq && !w_deq) begin
      r_cnt <= r_cnt + CntW'(1);
    end else if (w_deq && !w_enq) begin
      r_cnt <= r_cnt - CntW'(1);
    end
  end

  // Storage needs no reset: stale slots are hidden by the zeroing mux below.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_pc[w_wp]   <= if_pc;
      r_inst[w_wp] <= if_inst;
    end
  end

  assign if_ready = !w_full;
  assign id_valid = !w_empty;
  assign id_pc    = id_valid ? r_pc[w_rp]   : ADDR_W'(ZeroWord);
  assign id_inst  = id_valid ? r_inst[w_rp] : INST_W'(ZeroWord);
  assign count    = r_cnt;

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: a vector table of per-cycle inputs and
// expected outputs, cross-checked against a queue scoreboard of accepted entries.
module tb_if_id_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        ifv;
    logic [31:0] pc;
    logic        idr;
    logic        expReady;
    logic        expValid;
    logic [31:0] expPc;
    int          expCount;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready;
  logic [2:0]  count;

  vec_t        vecs[$];
  logic [31:0] sb[$];
  int          checks = 0;
  int          errors = 0;

  if_id_buffer #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .if_ready (if_ready),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .id_ready (id_ready),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instOf(input logic [31:0] pc);
    return {pc[15:0] ^ 16'hBEEF, pc[15:0]};
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic addVec(input logic r, input logic f, input logic ifv, input logic [31:0] pc,
                        input logic idr, input logic er, input logic ev, input logic [31:0] ep,
                        input int ec);
    vec_t v;
    v.rst = r; v.flush = f; v.ifv = ifv; v.pc = pc; v.idr = idr;
    v.expReady = er; v.expValid = ev; v.expPc = ep; v.expCount = ec;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, settle the scoreboard against the pre-edge head,
  // then advance past the clock edge.
  task automatic applyStimulus(input vec_t v);
    logic        wasFull;
    logic [31:0] head;
    rst      = v.rst;
    flush    = v.flush;
    if_valid = v.ifv;
    if_pc    = v.pc;
    if_inst  = instOf(v.pc);
    id_ready = v.idr;
    #1;
    wasFull = (sb.size() == DEPTH);
    if (v.rst || v.flush) begin
      sb.delete();
    end else begin
      if (v.idr && sb.size() > 0) begin
        head = sb.pop_front();
        checkVal("headValid", 32'(id_valid), 32'd1);
        checkVal("headPc", id_pc, head);
        checkVal("headInst", id_inst, instOf(head));
      end
      if (v.ifv && !wasFull) sb.push_back(v.pc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t v);
    checkVal("ifReady", 32'(if_ready), 32'(v.expReady));
    checkVal("idValid", 32'(id_valid), 32'(v.expValid));
    checkVal("idPc", id_pc, v.expValid ? v.expPc : 32'h0);
    checkVal("idInst", id_inst, v.expValid ? instOf(v.expPc) : 32'h0);
    checkVal("count", 32'(count), 32'(v.expCount));
    checkVal("sbCount", 32'(count), 32'(sb.size()));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0; id_ready = 1'b0;

    // Reset, then idle
    addVec(1, 0, 0, 32'h0,  0, 1, 0, 32'h0,  0);
    addVec(0, 0, 0, 32'h0,  1, 1, 0, 32'h0,  0);
    // Enqueue three under a decode stall, then drain in order
    addVec(0, 0, 1, 32'h0,  0, 1, 1, 32'h0,  1);
    addVec(0, 0, 1, 32'h4,  0, 1, 1, 32'h0,  2);
    addVec(0, 0, 1, 32'h8,  0, 1, 1, 32'h0,  3);
    addVec(0, 0, 0, 32'h0,  1, 1, 1, 32'h4,  2);
    addVec(0, 0, 0, 32'h0,  1, 1, 1, 32'h8,  1);
    addVec(0, 0, 0, 32'h0,  1, 1, 0, 32'h0,  0);
    // Fill to full, reject a fifth, full dequeue blocks same-cycle enqueue
    addVec(0, 0, 1, 32'h10, 0, 1, 1, 32'h10, 1);
    addVec(0, 0, 1, 32'h14, 0, 1, 1, 32'h10, 2);
    addVec(0, 0, 1, 32'h18, 0, 1, 1, 32'h10, 3);
    addVec(0, 0, 1, 32'h1C, 0, 0, 1, 32'h10, 4);
    addVec(0, 0, 1, 32'h20, 0, 0, 1, 32'h10, 4);
    addVec(0, 0, 1, 32'h20, 1, 1, 1, 32'h14, 3);
    addVec(0, 0, 0, 32'h0,  1, 1, 1, 32'h18, 2);
    addVec(0, 0, 0, 32'h0,  1, 1, 1, 32'h1C, 1);
    addVec(0, 0, 0, 32'h0,  1, 1, 0, 32'h0,  0);
    // Streaming ten entries with both sides always ready
    for (int i = 0; i < 10; i++)
      addVec(0, 0, 1, 32'h100 + 32'(4 * i), 1, 1, 1, 32'h100 + 32'(4 * i), 1);
    addVec(0, 0, 0, 32'h0,  1, 1, 0, 32'h0,  0);
    // Flush with a concurrent offer and consume; next entry follows normally
    addVec(0, 0, 1, 32'h30, 0, 1, 1, 32'h30, 1);
    addVec(0, 0, 1, 32'h34, 0, 1, 1, 32'h30, 2);
    addVec(0, 0, 1, 32'h38, 0, 1, 1, 32'h30, 3);
    addVec(0, 1, 1, 32'h40, 1, 1, 0, 32'h0,  0);
    addVec(0, 0, 1, 32'h80, 0, 1, 1, 32'h80, 1);
    addVec(0, 0, 0, 32'h0,  1, 1, 0, 32'h0,  0);
    // Reset while full and stalled
    addVec(0, 0, 1, 32'h200, 0, 1, 1, 32'h200, 1);
    addVec(0, 0, 1, 32'h204, 0, 1, 1, 32'h200, 2);
    addVec(0, 0, 1, 32'h208, 0, 1, 1, 32'h200, 3);
    addVec(0, 0, 1, 32'h20C, 0, 0, 1, 32'h200, 4);
    addVec(1, 0, 1, 32'h210, 1, 1, 0, 32'h0,   0);
    addVec(0, 0, 0, 32'h0,   0, 1, 0, 32'h0,   0);
    // Flush while full and stalled
    addVec(0, 0, 1, 32'h300, 0, 1, 1, 32'h300, 1);
    addVec(0, 0, 1, 32'h304, 0, 1, 1, 32'h300, 2);
    addVec(0, 0, 1, 32'h308, 0, 1, 1, 32'h300, 3);
    addVec(0, 0, 1, 32'h30C, 0, 0, 1, 32'h300, 4);
    addVec(0, 1, 0, 32'h0,   0, 1, 0, 32'h0,   0);
    addVec(0, 0, 1, 32'h310, 1, 1, 1, 32'h310, 1);
    addVec(0, 0, 0, 32'h0,   1, 1, 0, 32'h0,   0);

    @(posedge clk);
    #1;
    $display("[TB] applying %0d vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    checkVal("sbDrained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Parametrised instruction buffer between fetch (IF) and decode (ID), replacing a single IF/ID pipeline register with a DEPTH-entry FIFO. Each entry carries the pc/instruction pair. Valid/ready handshakes on both sides decouple fetch from decode stalls. A flush input (jump/branch redirect) discards every buffered entry in one cycle, and the block presents a zero bubble to ID whenever it is empty.

## Interface
Parameters:
- ADDR_W, 32, pc width
- INST_W, 32, instruction width
- DEPTH, 4, number of entries; power of two, ≥2

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  redirect; discard all entries
- if_valid  in  1  IF offers an entry this cycle
- if_pc  in  ADDR_W  pc of offered instruction
- if_inst  in  INST_W  offered instruction
- if_ready  out  1  buffer accepts; equals !full
- id_valid  out  1  head entry valid
- id_pc  out  ADDR_W  head pc; 0 when !id_valid
- id_inst  out  INST_W  head instruction; 0 when !id_valid
- id_ready  in  1  ID consumes head this cycle (0 = decode stall)
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Storage: DEPTH-entry circular array, with write pointer wp, read pointer rp and occupancy counter cnt.
- Enqueue: happens when if_valid && if_ready && !flush. The entry is written at wp, and wp wraps modulo DEPTH.
- Dequeue: happens when id_valid && id_ready && !flush. rp advances and wraps modulo DEPTH.
- Simultaneous enqueue and dequeue: cnt is unchanged.
- if_ready = (cnt != DEPTH). It depends only on state, with no combinational path from id_ready. When the buffer is full, a same-cycle dequeue does not allow a same-cycle enqueue.
- id_valid = (cnt != 0). id_pc and id_inst show the head entry when id_valid is 1, and are forced to 0 otherwise. A zero instruction is the pipeline bubble.
- Flush priority:
  - flush beats enqueue and dequeue in the same cycle.
  - On flush, wp, rp and cnt go to 0, and the incoming IF entry is dropped.
- Reset has the same effect as flush and overrides everything.
- Empty with id_ready high: no dequeue. Full with if_valid high: no enqueue, and IF must hold its data.

## Timing
- Reset values: if_ready=1, id_valid=0, id_pc=0, id_inst=0, count=0.
- Latency: no bypass. An entry enqueued at edge N is visible on id_* after edge N, so id_valid rises in cycle N+1 at the earliest. Throughput is 1 entry per cycle in steady state.
- Flush asserted in cycle N:
  - After edge N: id_valid=0, id_inst=0, count=0, if_ready=1.
  - First post-flush entry can be enqueued in cycle N+1 and is visible in N+2.
- Decode stall (id_ready=0): the head entry and id_* hold stable. Enqueues continue until full.
- Outputs are driven from registered state plus a zeroing mux only. There is no combinational input-to-output path except the ID consume/IF accept handshake evaluated at the clock edge.
- Reset or flush arriving while the buffer is full and stalled clears the buffer in one cycle, with no residual entries.

## Structure
- Shared package (defines): ZeroWord, RstEnable, True_v, and default ADDR_W/INST_W.
- pc and instruction are stored as separate arrays, or as one packed entry of ADDR_W+INST_W bits.
- Sub-module: ring_ptr. It is a parametrised modulo-DEPTH pointer with synchronous clear and increment, instantiated twice (wp, rp).
- Occupancy cnt is kept explicitly rather than derived from the pointers, so full and empty are unambiguous at DEPTH.

## Test plan
- Reset, then idle → if_ready=1, id_valid=0, id_pc=0, id_inst=0, count=0.
- Enqueue pc 0x0/0x4/0x8 with id_ready=0 → count=3, id_pc=0x0 held. Then set id_ready=1 → id_pc sequence 0x0, 0x4, 0x8 on consecutive cycles, then id_valid=0.
- Fill all 4 entries with id_ready=0 → if_ready=0 and count=4. A fifth if_valid is not accepted. Dequeue and enqueue in the same cycle while full → count=3, because the enqueue is not accepted.
- Stream of 10 entries with if_valid=id_ready=1 throughout → 1 entry/cycle, in order, pointers wrap, count stays at 1.
- Buffer holding 3 entries, then flush in the same cycle as if_valid (pc 0x40) and id_ready → next cycle count=0, id_inst=0, and 0x40 is never emitted. An enqueue of 0x80 in the following cycle appears one cycle later.
- rst asserted mid-stream while full → all outputs return to reset values after one edge.
